// File: rtl/gpt2_generation_sequencer.sv
// gpt2_generation_sequencer
// Autoregressive generation controller around a single-step gpt2_engine-style
// core. Prompt tokens are streamed in and issued to the core at increasing
// positions. After the last prompt token, each predicted token is emitted
// downstream and then fed back to the core until a stop condition is reached.
//
// Optional build macro: GEN_WATCHDOG_EN
//   When defined, a per-step watchdog runs while waiting on the core. If no
//   result arrives within TIMEOUT_CYCLES, err becomes 2 and the sequence ends.
//
// Handshake semantics (prompt and gen streams): a transfer happens on every
// rising clk edge where valid && ready are both high. A producer keeps valid
// and its payload stable until that edge. Neither ready depends
// combinationally on the matching valid.
module gpt2_generation_sequencer #(
  parameter int VOCAB_SIZE     = 16,
  parameter int MAX_SEQ_LEN    = 8,
  parameter int TOKEN_W        = $clog2(VOCAB_SIZE),
  parameter int POS_W          = $clog2(MAX_SEQ_LEN),
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   max_new_tokens,
  input  logic [TOKEN_W-1:0] eos_token,
  input  logic               prompt_valid,
  output logic               prompt_ready,
  input  logic [TOKEN_W-1:0] prompt_token,
  input  logic               prompt_last,
  output logic               eng_valid_in,
  output logic [TOKEN_W-1:0] eng_token_in,
  output logic [POS_W-1:0]   eng_position_in,
  input  logic               eng_valid_out,
  input  logic [TOKEN_W-1:0] eng_token_out,
  output logic               gen_valid,
  input  logic               gen_ready,
  output logic [TOKEN_W-1:0] gen_token,
  output logic [POS_W-1:0]   gen_position,
  output logic               gen_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROMPT = 3'd1,
    S_WAIT_P = 3'd2,
    S_WAIT_G = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [1:0]       ERR_NONE     = 2'd0;
  localparam logic [1:0]       ERR_OVERFLOW = 2'd1;

  state_t             state;
  state_t             state_next;

  logic [POS_W-1:0]   pos;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   max_q;
  logic [TOKEN_W-1:0] eos_q;
  logic               last_q;

  logic [POS_W-1:0]   pos_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               gen_last_c;
  logic               waiting;
  logic               wd_expired;

  // Saturating increments: position never passes the context end, counter never wraps.
  assign pos_inc = (pos == POS_MAX) ? pos : pos + POS_W'(1);
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
  assign waiting = (state == S_WAIT_P) || (state == S_WAIT_G);

  // Stop decision for the token currently presented on the gen stream.
  assign gen_last_c = (state == S_EMIT) &&
                      ((({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, max_q}) ||
                       (gen_token == eos_q) ||
                       (gen_position == POS_MAX));

`ifdef GEN_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      ERR_TIMEOUT = 2'd2;

  logic [WD_W-1:0] wd_cnt;

  // Per-step watchdog: counts cycles spent waiting for the core, cleared by a result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (waiting && !eng_valid_out && (wd_cnt != WD_LIMIT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // A result arriving in the same cycle as the limit wins over the timeout.
  assign wd_expired = waiting && (wd_cnt == WD_LIMIT) && !eng_valid_out;
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_PROMPT;
      end
      S_PROMPT: begin
        if (prompt_valid) state_next = S_WAIT_P;
      end
      S_WAIT_P: begin
        if (wd_expired) begin
          state_next = S_DONE;
        end else if (eng_valid_out) begin
          if (err == ERR_OVERFLOW)  state_next = S_DONE;
          else if (!last_q)         state_next = S_PROMPT;
          else if (max_q == '0)     state_next = S_DONE;
          else                      state_next = S_EMIT;
        end
      end
      S_WAIT_G: begin
        if (wd_expired)         state_next = S_DONE;
        else if (eng_valid_out) state_next = S_EMIT;
      end
      S_EMIT: begin
        if (gen_ready) state_next = gen_last_c ? S_DONE : S_WAIT_G;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    prompt_ready = (state == S_PROMPT);
    gen_valid    = (state == S_EMIT);
    gen_last     = gen_last_c;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
  end

  // Datapath: latched config, counters, core request and emitted token registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos             <= '0;
      cnt             <= '0;
      max_q           <= '0;
      eos_q           <= '0;
      last_q          <= 1'b0;
      err             <= ERR_NONE;
      eng_valid_in    <= 1'b0;
      eng_token_in    <= '0;
      eng_position_in <= '0;
      gen_token       <= '0;
      gen_position    <= '0;
    end else begin
      eng_valid_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            max_q  <= max_new_tokens;
            eos_q  <= eos_token;
            pos    <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
            err    <= ERR_NONE;
          end
        end
        S_PROMPT: begin
          if (prompt_valid) begin
            eng_valid_in    <= 1'b1;
            eng_token_in    <= prompt_token;
            eng_position_in <= pos;
            last_q          <= prompt_last;
            // No room left for the next prompt token: flag it now, finish on the result.
            if (!prompt_last && (pos == POS_MAX)) err <= ERR_OVERFLOW;
          end
        end
        S_WAIT_P: begin
          if (eng_valid_out && (err != ERR_OVERFLOW)) begin
            if (!last_q) begin
              pos <= pos_inc;
            end else if (max_q != '0) begin
              gen_token    <= eng_token_out;
              gen_position <= pos_inc;
            end
          end
        end
        S_WAIT_G: begin
          if (eng_valid_out) begin
            gen_token    <= eng_token_out;
            gen_position <= pos_inc;
          end
        end
        S_EMIT: begin
          if (gen_ready) begin
            cnt <= cnt_inc;
            if (!gen_last_c) begin
              eng_valid_in    <= 1'b1;
              eng_token_in    <= gen_token;
              eng_position_in <= gen_position;
              pos             <= gen_position;
            end
          end
        end
        default: begin
        end
      endcase
`ifdef GEN_WATCHDOG_EN
      if (wd_expired) err <= ERR_TIMEOUT;
`endif
    end
  end

endmodule
